mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Multi-cycle shift-and-add multiply sequencer for the execute stage.
- Time-shares the single execute-stage ALU: in IDLE it passes the pipeline's ALU operands straight through; while a multiply runs it takes the ALU and issues one ADD per set multiplier bit.
- Produces the low 32 bits of the product (MUL semantics) plus N/Z flags.
- Stalls the pipeline while it owns the ALU.

Parameters:
- ADD_CTRL, 3'b000, ALUControl encoding the sequencer drives for a plain add (a + b, no inversion).
- WIDTH, 32, operand/product width. Fixed at 32 to match the ALU; other values are unsupported.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a multiply; sampled only in IDLE
- flush  in  1  synchronous abort of an in-flight multiply
- multiplicand  in  32  operand A, captured on accepted start
- multiplier  in  32  operand B, captured on accepted start
- ex_a  in  32  pipeline ALU operand a (pass-through path)
- ex_b  in  32  pipeline ALU operand b (pass-through path)
- ex_ctrl  in  3  pipeline ALUControl (pass-through path)
- alu_a  out  32  to shared ALU a
- alu_b  out  32  to shared ALU b
- alu_ctrl  out  3  to shared ALU ALUControl
- alu_result  in  32  from shared ALU Result
- busy  out  1  sequencer owns, or is about to own, the ALU; pipeline stall
- done  out  1  one-cycle pulse, product valid
- product  out  32  low 32 bits of multiplicand*multiplier; held until next accepted start
- product_nz  out  2  {product[31], product==0}

Behaviour:
- States: IDLE, RUN, DONE.
- Internal registers: mcand[31:0], mplier[31:0], acc[31:0].
- Reset (async, any state): state=IDLE; mcand, mplier and acc cleared to 0; done=0; product=0; product_nz=2'b01.
- IDLE:
  - alu_a=ex_a, alu_b=ex_b, alu_ctrl=ex_ctrl; purely combinational, zero added latency.
  - On start=1 (and flush=0): mcand<=multiplicand, mplier<=multiplier, acc<=0.
  - Next state is DONE if multiplier==0 (product 0), else RUN.
- RUN, one iteration per cycle:
  - alu_a=acc, alu_b=mcand, alu_ctrl=ADD_CTRL.
  - If mplier[0]=1, acc<=alu_result; else acc holds.
  - mcand<=mcand<<1; mplier<=mplier>>1.
  - Exit to DONE when (mplier>>1)==0, i.e. after the most significant set bit is processed.
  - Iterations = msb_index(multiplier)+1, range 1..32.
  - Overflow above bit 31 is discarded: the ALU sum is 32-bit and its carry/overflow flags are ignored.
- DONE (one cycle):
  - done=1; product and product_nz take the final acc value on entry to DONE.
  - ALU mux returns to pass-through.
  - Next state IDLE unconditionally; start is not sampled in DONE.
- busy = (state==RUN) | (state==IDLE & start & ~flush). This makes the stall assert in the same cycle the start is accepted.
- Latency: start at edge N gives done at N+1+iterations (multiplier≠0) or N+1 (multiplier=0).
- Boundary rules:
  - start while RUN/DONE: ignored, no queuing.
  - flush in RUN: next state IDLE, acc discarded, no done pulse, product keeps its previous value.
  - flush in IDLE together with start: start is ignored.
  - flush in DONE: no effect; done still pulses.
  - reset mid-RUN: immediate IDLE, outputs go to their reset values.
  - A multiplicand shifted out past bit 31 contributes 0.

Test Plan:
- Reset then IDLE pass-through: ex_a=7, ex_b=9, ex_ctrl=3'b011 -> alu_a=7, alu_b=9, alu_ctrl=3'b011 in the same cycle; busy=0.
- start, 3 x 5: busy=1 on the start cycle; 3 RUN cycles with alu_ctrl=000 and acc sequence 3,3,15 -> done pulse 4 cycles after start; product=15, product_nz=2'b00.
- start, multiplier=0, multiplicand=0x1234 -> no RUN cycles; done on the next cycle; product=0, product_nz=2'b01.
- start, 0xFFFFFFFF x 0xFFFFFFFF -> 32 RUN cycles; done at start+33; product=0x00000001.
- Second start asserted during RUN of 6 x 7 -> ignored; product=42; then a fresh start 2 x 0x80000000 -> product=0x00000000, product_nz=2'b01, 32 iterations.
- Interrupted 6 x 7: flush at RUN cycle 2 -> IDLE next cycle, no done, product keeps its prior value. Repeat with reset asserted mid-RUN -> immediate IDLE, product=0, busy=0.

Source files
------------

// File: rtl/mul_seq_if.sv
// rtl/mul_seq_if.sv - multiply sequencer bus: pipeline operands, shared ALU port, status
interface mul_seq_if;
  logic        start;
  logic        flush;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [2:0]  ex_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [1:0]  product_nz;

  modport slave (
    input  start, flush, multiplicand, multiplier, ex_a, ex_b, ex_ctrl, alu_result,
    output alu_a, alu_b, alu_ctrl, busy, done, product, product_nz
  );

  modport master (
    output start, flush, multiplicand, multiplier, ex_a, ex_b, ex_ctrl, alu_result,
    input  alu_a, alu_b, alu_ctrl, busy, done, product, product_nz
  );
endinterface

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - shift-and-add multiply sequencer sharing the execute-stage ALU
module mul_seq #(
  parameter logic [2:0] ADD_CTRL = 3'b000,
  parameter int         WIDTH    = 32
) (
  input logic         clk,
  input logic         reset,
  mul_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_product;
  logic [1:0]         r_product_nz;
  logic               w_accept;
  logic               w_enter_done;
  logic [WIDTH-1:0]   w_acc_next;

  // A start only counts in IDLE and loses to a simultaneous flush.
  assign w_accept     = (r_state == S_IDLE) && bus.start && !bus.flush;
  assign w_enter_done = (r_state != S_DONE) && (w_next == S_DONE);

  // Accumulator value after this cycle's iteration; zero outside RUN so a zero multiplier yields 0.
  always_comb begin
    w_acc_next = '0;
    if (r_state == S_RUN) begin
      w_acc_next = r_mplier[0] ? bus.alu_result : r_acc;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: RUN ends once the top set multiplier bit has been consumed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (bus.multiplier == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          w_next = S_IDLE;
        end else if ((r_mplier >> 1) == '0) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: ALU mux is pass-through except in RUN; busy covers the accepting cycle too.
  always_comb begin
    bus.alu_a    = bus.ex_a;
    bus.alu_b    = bus.ex_b;
    bus.alu_ctrl = bus.ex_ctrl;
    bus.busy     = w_accept;
    bus.done     = 1'b0;
    case (r_state)
      S_RUN: begin
        bus.alu_a    = r_acc;
        bus.alu_b    = r_mcand;
        bus.alu_ctrl = ADD_CTRL;
        bus.busy     = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and per-iteration shift; bits shifted past the top simply fall off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (w_accept) begin
      r_mcand  <= bus.multiplicand;
      r_mplier <= bus.multiplier;
      r_acc    <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  // Result register: loaded only on entry to DONE, so a flushed run leaves it untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_product    <= '0;
      r_product_nz <= 2'b01;
    end else if (w_enter_done) begin
      r_product    <= w_acc_next;
      r_product_nz <= {w_acc_next[WIDTH-1], (w_acc_next == '0)};
    end
  end

  assign bus.product    = r_product;
  assign bus.product_nz = r_product_nz;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed self-checking bench for mul_seq
module tb_mul_seq;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mul_seq_if bus();

  mul_seq #(.ADD_CTRL(3'b000), .WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU stand-in: adds on 000, returns a marker pattern otherwise.
  always_comb begin
    bus.alu_result = (bus.alu_ctrl == 3'b000) ? (bus.alu_a + bus.alu_b) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Start a multiply and follow it cycle by cycle until done, modelling the accumulator.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_p, input logic [1:0] exp_nz,
                         input int iters, input bit poke);
    logic [31:0] exp_acc;
    bit          got_done;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    #1;
    check("busy_on_start", {31'd0, bus.busy}, 32'd1);
    exp_acc  = '0;
    got_done = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
      @(negedge clk);
      bus.start = poke && (cyc == 2);
      if (poke && cyc == 2) begin
        bus.multiplicand = 32'd9;
        bus.multiplier   = 32'd9;
      end
      #1;
      if (bus.done) begin
        got_done = 1'b1;
        check("latency", cyc, iters + 1);
        check("product", bus.product, exp_p);
        check("product_nz", {30'd0, bus.product_nz}, {30'd0, exp_nz});
        check("busy_in_done", {31'd0, bus.busy}, 32'd0);
      end else begin
        check("busy_run", {31'd0, bus.busy}, 32'd1);
        check("alu_ctrl_run", {29'd0, bus.alu_ctrl}, 32'd0);
        check("alu_a_acc", bus.alu_a, exp_acc);
        check("alu_b_mcand", bus.alu_b, a << (cyc - 1));
        if (cyc <= 32 && b[cyc-1]) exp_acc = exp_acc + (a << (cyc - 1));
      end
    end
    if (!got_done) check("done_timeout", 32'd0, 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    #1;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
  endtask

  // Start 6x7, then abort at RUN cycle 2 with flush or with reset.
  task automatic abort_mul(input bit use_reset, input logic [31:0] prior_p, input logic [1:0] prior_nz);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 32'd6;
    bus.multiplier   = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    if (use_reset) begin
      reset = 1'b1;
      #1;
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_product", bus.product, 32'd0);
      check("rst_nz", {30'd0, bus.product_nz}, 32'd1);
      check("rst_passthru", bus.alu_a, bus.ex_a);
      @(negedge clk);
      reset = 1'b0;
    end else begin
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      check("flush_busy", {31'd0, bus.busy}, 32'd0);
      check("flush_passthru_ctrl", {29'd0, bus.alu_ctrl}, {29'd0, bus.ex_ctrl});
      for (int i = 0; i < 5; i++) begin
        check("flush_no_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        #1;
      end
      check("flush_product", bus.product, prior_p);
      check("flush_nz", {30'd0, bus.product_nz}, {30'd0, prior_nz});
    end
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.flush        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.ex_a         = '0;
    bus.ex_b         = '0;
    bus.ex_ctrl      = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_product", bus.product, 32'd0);
    check("reset_nz", {30'd0, bus.product_nz}, 32'd1);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;

    @(negedge clk);
    bus.ex_a    = 32'd7;
    bus.ex_b    = 32'd9;
    bus.ex_ctrl = 3'b011;
    #1;
    check("pass_a", bus.alu_a, 32'd7);
    check("pass_b", bus.alu_b, 32'd9);
    check("pass_ctrl", {29'd0, bus.alu_ctrl}, 32'd3);
    check("pass_busy", {31'd0, bus.busy}, 32'd0);

    run_mul(32'd3, 32'd5, 32'd15, 2'b00, 3, 1'b0);
    run_mul(32'h0000_1234, 32'd0, 32'd0, 2'b01, 0, 1'b0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 2'b00, 32, 1'b0);
    run_mul(32'd6, 32'd7, 32'd42, 2'b00, 3, 1'b1);
    run_mul(32'd2, 32'h8000_0000, 32'd0, 2'b01, 32, 1'b0);
    run_mul(32'h0001_0000, 32'h0000_8001, 32'h8001_0000, 2'b10, 16, 1'b0);

    // start blocked by a simultaneous flush in IDLE
    @(negedge clk);
    bus.start        = 1'b1;
    bus.flush        = 1'b1;
    bus.multiplicand = 32'd4;
    bus.multiplier   = 32'd4;
    #1;
    check("idle_flush_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("idle_flush_no_run", {31'd0, bus.busy}, 32'd0);
    check("idle_flush_pass", bus.alu_a, 32'd7);

    run_mul(32'd3, 32'd5, 32'd15, 2'b00, 3, 1'b0);
    abort_mul(1'b0, 32'd15, 2'b00);
    abort_mul(1'b1, 32'd0, 2'b01);
    run_mul(32'd6, 32'd7, 32'd42, 2'b00, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
